hex_display_scroller: RTL and testbench

//   Registered multi-digit hex display driver for the board's 7-segment bank. Latches a WORD_DIGITS-nibble

---
 rtl/hex_display_scroller.sv | 139 +++++++++++++
 tb/tb_hex_display_scroller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scroller.sv
// hex_display_scroller: registered 7-segment hex driver with
// leading-zero blanking, per-digit blink and rotating scroll.
module hex_display_scroller #(
  parameter int NDIGITS     = 4,
  parameter int WORD_DIGITS = 8,
  parameter int TICK_DIV    = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*WORD_DIGITS-1:0] in_data,
  input  logic                     in_scroll,
  input  logic                     in_lzb,
  input  logic [NDIGITS-1:0]       in_blink,
  output logic [7*NDIGITS-1:0]     HEX,
  output logic                     wrap_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OMAX = OW'(WORD_DIGITS - 1);

  logic [4*WORD_DIGITS-1:0] r_value;
  logic                     r_scroll;
  logic                     r_lzb;
  logic [NDIGITS-1:0]       r_mask;
  logic [OW-1:0]            r_offset;
  logic [TW-1:0]            r_tick_cnt;
  logic                     r_phase;
  logic                     r_ready;
  logic                     r_wrap;
  logic [7*NDIGITS-1:0]     r_hex;
  logic [7*NDIGITS-1:0]     w_hex;
  logic                     w_load;
  logic                     w_tick;

  assign w_load     = in_valid & r_ready;
  assign w_tick     = (r_tick_cnt == TMAX);
  assign in_ready   = r_ready;
  assign HEX        = r_hex;
  assign wrap_pulse = r_wrap;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    unique case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
    endcase
  endfunction

  // accept loads once out of reset
  always_ff @(posedge clk) begin
    if (reset) r_ready <= 1'b0;
    else       r_ready <= 1'b1;
  end

  // latch content, run tick divider, blink phase and scroll offset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value    <= '0;
      r_scroll   <= 1'b0;
      r_lzb      <= 1'b0;
      r_mask     <= '0;
      r_offset   <= '0;
      r_tick_cnt <= '0;
      r_phase    <= 1'b0;
      r_wrap     <= 1'b0;
    end else if (w_load) begin
      r_value    <= in_data;
      r_scroll   <= in_scroll;
      r_lzb      <= in_lzb;
      r_mask     <= in_blink;
      r_offset   <= '0;
      r_tick_cnt <= '0;
      r_phase    <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_tick) begin
        r_tick_cnt <= '0;
        r_phase    <= ~r_phase;
        if (r_scroll) begin
          if (r_offset == OMAX) begin
            r_offset <= '0;
            r_wrap   <= 1'b1;
          end else begin
            r_offset <= r_offset + 1'b1;
          end
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  // window select, blanking and decode from registered state
  always_comb begin
    logic       w_chain;
    logic       w_blank;
    logic [3:0] w_nib;
    int         w_idx;
    w_hex   = '1;
    w_chain = r_lzb & ~r_scroll;
    w_blank = 1'b0;
    w_nib   = '0;
    w_idx   = 0;
    for (int p = NDIGITS - 1; p >= 0; p--) begin
      w_idx = int'(r_offset) + p;
      if (w_idx >= WORD_DIGITS) w_idx = w_idx - WORD_DIGITS;
      w_nib = r_value[4*w_idx +: 4];
      if (p == 0) w_chain = 1'b0;
      else        w_chain = w_chain & (w_nib == 4'h0);
      w_blank = w_chain | (r_phase & r_mask[p]);
      w_hex[7*p +: 7] = w_blank ? 7'h7F : seg7(w_nib);
    end
  end

  // register the segment outputs
  always_ff @(posedge clk) begin
    if (reset) r_hex <= '1;
    else       r_hex <= w_hex;
  end

endmodule

// File: tb/tb_hex_display_scroller.sv
// tb_hex_display_scroller: directed vectors plus scroll,
// blink and load/tick/reset collision sequences.
module tb_hex_display_scroller;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_scroll;
  logic        in_lzb;
  logic [3:0]  in_blink;
  logic [27:0] HEX;
  logic        wrap_pulse;

  int checks = 0;
  int errors = 0;

  hex_display_scroller #(
    .NDIGITS(4), .WORD_DIGITS(8), .TICK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_scroll(in_scroll),
    .in_lzb(in_lzb), .in_blink(in_blink),
    .HEX(HEX), .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        scroll;
    logic        lzb;
    logic [3:0]  blink;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [6:0] seg [16];

  function automatic logic [27:0] h4(input logic [6:0] p3, p2, p1, p0);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [27:0] win(input logic [31:0] v, input int off);
    logic [27:0] r;
    int d;
    r = '0;
    for (int p = 0; p < 4; p++) begin
      d = (off + p) % 8;
      r[7*p +: 7] = seg[v[4*d +: 4]];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] d, input logic sc,
                      input logic lz, input logic [3:0] bl);
    in_data   = d;
    in_scroll = sc;
    in_lzb    = lz;
    in_blink  = bl;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  logic [31:0] v;
  int          nwrap;
  int          wedge;

  initial begin
    seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{32'h0000_00A5, 0, 1, 4'h0, h4(7'h7F, 7'h7F, 7'h08, 7'h12)};
    vecs[1] = '{32'h0000_0000, 0, 1, 4'h0, h4(7'h7F, 7'h7F, 7'h7F, 7'h40)};
    vecs[2] = '{32'h0000_0000, 0, 0, 4'h0, h4(7'h40, 7'h40, 7'h40, 7'h40)};
    vecs[3] = '{32'h0000_1234, 0, 0, 4'h0, h4(7'h79, 7'h24, 7'h30, 7'h19)};
    vecs[4] = '{32'h0000_0F0E, 0, 1, 4'h0, h4(7'h7F, 7'h0E, 7'h40, 7'h06)};
    vecs[5] = '{32'hFFFF_0070, 0, 1, 4'h0, h4(7'h7F, 7'h7F, 7'h78, 7'h40)};
    vecs[6] = '{32'h89AB_CDEF, 0, 0, 4'h0, h4(7'h46, 7'h21, 7'h06, 7'h0E)};
    vecs[7] = '{32'h0000_0000, 1, 1, 4'h0, h4(7'h40, 7'h40, 7'h40, 7'h40)};
    vecs[8] = '{32'h0000_5000, 0, 1, 4'h0, h4(7'h12, 7'h40, 7'h40, 7'h40)};
    vecs[9] = '{32'h0000_0B67, 0, 0, 4'hF, h4(7'h40, 7'h03, 7'h02, 7'h78)};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_scroll = 1'b0;
    in_lzb    = 1'b0;
    in_blink  = '0;

    // reset
    repeat (3) step();
    chk("rst_hex", 32'(HEX), 32'h0FFF_FFFF);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wrap", 32'(wrap_pulse), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_before", 32'(in_ready), 0);
    step();
    chk("ready_after", 32'(in_ready), 1);

    // static vectors, HEX two edges after presentation
    for (int i = 0; i < 10; i++) begin
      load(vecs[i].data, vecs[i].scroll, vecs[i].lzb, vecs[i].blink);
      step();
      chk($sformatf("vec%0d_hex", i), 32'(HEX), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 1);
    end

    // scroll through all eight offsets and wrap
    v = 32'h7654_3210;
    load(v, 1'b1, 1'b0, 4'h0);
    nwrap = 0;
    wedge = -1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (wrap_pulse) begin
        nwrap++;
        wedge = e;
      end
      if (e >= 2 && (e - 2) % 4 == 0)
        chk($sformatf("scroll_k%0d", (e - 2) / 4), 32'(HEX),
            32'(win(v, ((e - 2) / 4) % 8)));
    end
    chk("wrap_count", 32'(nwrap), 1);
    chk("wrap_edge", 32'(wedge), 32);

    // blink on position 0
    load(32'h0000_1234, 1'b0, 1'b0, 4'b0001);
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 3 || e == 10)
        chk($sformatf("blink_on_e%0d", e), 32'(HEX),
            32'(h4(7'h79, 7'h24, 7'h30, 7'h19)));
      if (e == 6 || e == 14)
        chk($sformatf("blink_off_e%0d", e), 32'(HEX),
            32'(h4(7'h79, 7'h24, 7'h30, 7'h7F)));
    end

    // load colliding with tick: no step
    load(v, 1'b1, 1'b0, 4'h0);
    repeat (3) step();
    load(v, 1'b1, 1'b0, 4'h0);
    step();
    step();
    chk("coll_e2", 32'(HEX), 32'(win(v, 0)));
    step();
    step();
    chk("coll_e4", 32'(HEX), 32'(win(v, 0)));
    step();
    step();
    chk("coll_e6", 32'(HEX), 32'(win(v, 1)));

    // reset mid-scroll with a pending load
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_1234;
    step();
    chk("mid_rst_hex", 32'(HEX), 32'h0FFF_FFFF);
    chk("mid_rst_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
    chk("post_rst_ready", 32'(in_ready), 1);
    for (int e = 0; e < 8; e++) begin
      step();
      if (wrap_pulse) nwrap++;
    end
    chk("post_rst_hex", 32'(HEX), 32'(h4(7'h40, 7'h40, 7'h40, 7'h40)));
    chk("post_rst_nowrap", 32'(nwrap), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
